// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate strobe, h/v counters, decoded blanking, and a
// one-pixel-delayed output stage that keeps sync and colour aligned at the pins.
module vga_timing_gen #(
    parameter int unsigned PIX_DIV  = 2,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       r_i,
    input  logic       g_i,
    input  logic       b_i,
    output logic       pix_en_o,
    output logic [9:0] x_o,
    output logic [9:0] y_o,
    output logic       de_o,
    output logic       line_start_o,
    output logic       frame_start_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       r_o,
    output logic       g_o,
    output logic       b_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    if (H_TOTAL > 1024 || V_TOTAL > 1024 || PIX_DIV < 1) begin : g_bad_params
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must be <= 1024 and PIX_DIV >= 1");
    end

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

    // 11-bit bounds so a sync pulse ending exactly at a 1024 total still decodes correctly.
    localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [9:0]       h_cnt_q, h_cnt_d;
    logic [9:0]       v_cnt_q, v_cnt_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic [2:0]       rgb_q, rgb_d;

    logic        pix_en;
    logic        h_wrap;
    logic        v_wrap;
    logic        de;
    logic        hs;
    logic        vs;
    logic [10:0] h_ext;
    logic [10:0] v_ext;

    always_comb begin
        h_ext  = {1'b0, h_cnt_q};
        v_ext  = {1'b0, v_cnt_q};
        pix_en = (div_cnt_q == DIV_LAST);
        h_wrap = (h_cnt_q == H_LAST);
        v_wrap = (v_cnt_q == V_LAST);
        de     = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
        hs     = (h_ext >= HS_START) && (h_ext < HS_END);
        vs     = (v_ext >= VS_START) && (v_ext < VS_END);

        div_cnt_d = pix_en ? '0 : div_cnt_q + DIV_W'(1);
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        if (pix_en) begin
            h_cnt_d = h_wrap ? '0 : h_cnt_q + 10'd1;
            if (h_wrap) begin
                v_cnt_d = v_wrap ? '0 : v_cnt_q + 10'd1;
            end
        end

        // Output stage samples the coordinate-derived values of the pixel just ending.
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        rgb_d   = rgb_q;
        if (pix_en) begin
            hsync_d = hs ? SYNC_POL : ~SYNC_POL;
            vsync_d = vs ? SYNC_POL : ~SYNC_POL;
            rgb_d   = {r_i, g_i, b_i} & {3{de}};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_cnt_q <= '0;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            hsync_q   <= ~SYNC_POL;
            vsync_q   <= ~SYNC_POL;
            rgb_q     <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            rgb_q     <= rgb_d;
        end
    end

    assign pix_en_o      = pix_en;
    assign x_o           = h_cnt_q;
    assign y_o           = v_cnt_q;
    assign de_o          = de;
    assign line_start_o  = pix_en & h_wrap;
    assign frame_start_o = pix_en & h_wrap & v_wrap;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign r_o           = rgb_q[2];
    assign g_o           = rgb_q[1];
    assign b_o           = rgb_q[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three builds (default 640x480, tiny PIX_DIV=1, tiny PIX_DIV=3 active-high)
// checked every cycle against a closed-form raster model plus directed literal expectations.
module tb_vga_timing_gen;

    localparam int G_DIV [3] = '{2, 1, 3};
    localparam int G_HA  [3] = '{640, 8, 8};
    localparam int G_HFP [3] = '{16, 2, 2};
    localparam int G_HS  [3] = '{96, 2, 2};
    localparam int G_HBP [3] = '{48, 2, 2};
    localparam int G_VA  [3] = '{480, 4, 4};
    localparam int G_VFP [3] = '{10, 1, 1};
    localparam int G_VS  [3] = '{2, 1, 1};
    localparam int G_VBP [3] = '{33, 1, 1};
    localparam bit G_POL [3] = '{1'b0, 1'b0, 1'b1};

    typedef struct packed {
        logic       pix_en;
        logic [9:0] x;
        logic [9:0] y;
        logic       de;
        logic       ls;
        logic       fs;
        logic       hs;
        logic       vs;
        logic [2:0] rgb;
    } exp_t;

    logic       clk = 1'b0;
    logic [2:0] rst;
    logic [2:0] rgb_in [3];
    logic       pix_en [3];
    logic [9:0] xo [3];
    logic [9:0] yo [3];
    logic       de [3], ls [3], fs [3], hs [3], vs [3], ro [3], go [3], bo [3];

    int t [3]     = '{0, 0, 0};
    bit armed [3] = '{1'b0, 1'b0, 1'b0};
    int mode [3];
    int checks    = 0;
    int failures  = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        vga_timing_gen #(
            .PIX_DIV (G_DIV[gi]),
            .H_ACTIVE(G_HA[gi]),
            .H_FP    (G_HFP[gi]),
            .H_SYNC  (G_HS[gi]),
            .H_BP    (G_HBP[gi]),
            .V_ACTIVE(G_VA[gi]),
            .V_FP    (G_VFP[gi]),
            .V_SYNC  (G_VS[gi]),
            .V_BP    (G_VBP[gi]),
            .SYNC_POL(G_POL[gi])
        ) dut (
            .clk_i        (clk),
            .rst_i        (rst[gi]),
            .r_i          (rgb_in[gi][2]),
            .g_i          (rgb_in[gi][1]),
            .b_i          (rgb_in[gi][0]),
            .pix_en_o     (pix_en[gi]),
            .x_o          (xo[gi]),
            .y_o          (yo[gi]),
            .de_o         (de[gi]),
            .line_start_o (ls[gi]),
            .frame_start_o(fs[gi]),
            .hsync_o      (hs[gi]),
            .vsync_o      (vs[gi]),
            .r_o          (ro[gi]),
            .g_o          (go[gi]),
            .b_o          (bo[gi])
        );
    end

    // Cycles elapsed since the last clock edge that saw reset; 0 is the reset state itself.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst[k]) begin
                t[k]     <= 0;
                armed[k] <= 1'b1;
            end else begin
                t[k] <= t[k] + 1;
            end
        end
    end

    function automatic logic [2:0] pat(input int x, input int y, input int m);
        if (m == 0) return 3'b111;
        return {1'(x ^ y), 1'(x >> 1), ((x + y) % 3) == 0};
    endfunction

    // Raster position is pixel number n = t / PIX_DIV; pins show pixel n-1.
    function automatic exp_t model(input int k, input int tt);
        exp_t e;
        int ht, vt, n, x, y, px, py, hs0, vs0;
        ht  = G_HA[k] + G_HFP[k] + G_HS[k] + G_HBP[k];
        vt  = G_VA[k] + G_VFP[k] + G_VS[k] + G_VBP[k];
        hs0 = G_HA[k] + G_HFP[k];
        vs0 = G_VA[k] + G_VFP[k];
        n   = tt / G_DIV[k];
        x   = n % ht;
        y   = (n / ht) % vt;
        e.pix_en = (tt % G_DIV[k]) == G_DIV[k] - 1;
        e.x      = 10'(x);
        e.y      = 10'(y);
        e.de     = (x < G_HA[k]) && (y < G_VA[k]);
        e.ls     = e.pix_en && (x == ht - 1);
        e.fs     = e.ls && (y == vt - 1);
        if (n == 0) begin
            e.hs  = ~G_POL[k];
            e.vs  = ~G_POL[k];
            e.rgb = 3'b000;
        end else begin
            px    = (n - 1) % ht;
            py    = ((n - 1) / ht) % vt;
            e.hs  = (px >= hs0 && px < hs0 + G_HS[k]) ? G_POL[k] : ~G_POL[k];
            e.vs  = (py >= vs0 && py < vs0 + G_VS[k]) ? G_POL[k] : ~G_POL[k];
            e.rgb = (px < G_HA[k] && py < G_VA[k]) ? pat(px, py, mode[k]) : 3'b000;
        end
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic cmp_loop();
        exp_t e;
        logic [28:0] act;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (armed[k]) begin
                    e   = model(k, t[k]);
                    act = {pix_en[k], xo[k], yo[k], de[k], ls[k], fs[k], hs[k], vs[k], ro[k], go[k], bo[k]};
                    checks++;
                    if (act !== e) begin
                        failures++;
                        $display("FAIL cycle_cmp dut=%0d t=%0d actual=%h expected=%h", k, t[k], act, e);
                    end
                end
            end
        end
    endtask

    // Colour follows the pixel on strobe cycles and is junk otherwise, so off-strobe sampling shows up.
    task automatic drive_loop();
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                e = model(k, t[k]);
                rgb_in[k] = e.pix_en ? pat(int'(e.x), int'(e.y), mode[k]) : 3'($urandom_range(0, 7));
            end
        end
    endtask

    // Counts over one line (build 0) and m frames (builds 1, 2); totals are phase-independent.
    task automatic measure(input int m);
        int w [3];
        int c_pix [3], c_h [3], c_v [3], c_r [3], c_ls [3], c_fs [3];
        w = '{1600, 98 * m, 294 * m};
        for (int k = 0; k < 3; k++) begin
            c_pix[k] = 0; c_h[k] = 0; c_v[k] = 0; c_r[k] = 0; c_ls[k] = 0; c_fs[k] = 0;
        end
        for (int i = 0; i < 294 * m || i < 1600; i++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (i < w[k]) begin
                    c_pix[k] += int'(pix_en[k]);
                    c_h[k]   += int'(hs[k] == G_POL[k]);
                    c_v[k]   += int'(vs[k] == G_POL[k]);
                    c_r[k]   += int'(ro[k]);
                    c_ls[k]  += int'(ls[k]);
                    c_fs[k]  += int'(fs[k]);
                end
            end
        end
        check("d0_pix_en_per_line", c_pix[0], 800);
        check("d0_hsync_low_per_line", c_h[0], 192);
        check("d0_vsync_low_in_line", c_v[0], 0);
        check("d0_r_high_per_line", c_r[0], 1280);
        check("d0_line_start_per_line", c_ls[0], 1);
        check("d0_frame_start_in_line", c_fs[0], 0);
        check("d1_r_high_per_frames", c_r[1], 32 * m);
        for (int k = 1; k < 3; k++) begin
            check($sformatf("d%0d_pix_en_per_frames", k), c_pix[k], 98 * m);
            check($sformatf("d%0d_hsync_act_per_frames", k), c_h[k], 14 * m * G_DIV[k]);
            check($sformatf("d%0d_vsync_act_per_frames", k), c_v[k], 14 * m * G_DIV[k]);
            check($sformatf("d%0d_line_start_per_frames", k), c_ls[k], 7 * m);
            check($sformatf("d%0d_frame_start_per_frames", k), c_fs[k], m);
        end
    endtask

    initial begin
        exp_t me;
        int n, gap, vl, hl, rh, fc;
        rst  = 3'b111;
        mode = '{0, 0, 1};

        // Pin the model against hand-derived values for the full-size raster.
        me = model(0, 1313);
        check("model_hsync_before_656", int'(me.hs), 1);
        me = model(0, 1315);
        check("model_hsync_after_656", int'(me.hs), 0);
        me = model(0, 839999);
        check("model_frame_end_fs", int'(me.fs), 1);
        check("model_frame_end_x", int'(me.x), 799);
        check("model_frame_end_y", int'(me.y), 524);
        me = model(0, 840001);
        check("model_frame_wrap_xy", int'(me.x) + int'(me.y), 0);
        vl = 0; hl = 0; rh = 0; fc = 0;
        for (int tt = 2; tt < 840002; tt++) begin
            me  = model(0, tt);
            vl += int'(me.vs == 1'b0);
            hl += int'(me.hs == 1'b0);
            rh += int'(me.rgb[2]);
            fc += int'(me.fs);
        end
        check("model_vsync_low_per_frame", vl, 3200);
        check("model_hsync_low_per_frame", hl, 100800);
        check("model_r_high_per_frame", rh, 614400);
        check("model_frame_start_per_frame", fc, 1);

        fork
            cmp_loop();
            drive_loop();
        join_none

        repeat (3) @(negedge clk);
        check("rst_d0_x", int'(xo[0]), 0);
        check("rst_d0_y", int'(yo[0]), 0);
        check("rst_d0_hsync", int'(hs[0]), 1);
        check("rst_d0_vsync", int'(vs[0]), 1);
        check("rst_d0_rgb", int'({ro[0], go[0], bo[0]}), 0);
        check("rst_d0_pix_en", int'(pix_en[0]), 0);
        check("rst_d1_pix_en", int'(pix_en[1]), 1);
        check("rst_d2_hsync", int'(hs[2]), 0);
        rst = 3'b000;

        @(negedge clk);
        check("d0_first_pix_en", int'(pix_en[0]), 1);
        check("d0_first_x", int'(xo[0]), 0);
        check("d2_no_pix_en_at_1", int'(pix_en[2]), 0);
        check("d1_x_at_1", int'(xo[1]), 1);

        n = 0;
        while (xo[0] != 10'd656 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("d0_reach_x656", int'(xo[0]), 656);
        gap = 0;
        while (hs[0] !== 1'b0 && gap < 10) begin
            @(negedge clk);
            gap++;
        end
        check("d0_hsync_fall_after_x656", gap, 2);

        measure(1);
        measure(10);

        n = 0;
        while (fs[1] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("d1_fs_x", int'(xo[1]), 13);
        check("d1_fs_y", int'(yo[1]), 6);
        @(negedge clk);
        check("d1_after_fs_x", int'(xo[1]), 0);
        check("d1_after_fs_y", int'(yo[1]), 0);

        n = 0;
        while (xo[0] != 10'd300 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("d0_reach_x300", int'(xo[0]), 300);
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        @(negedge clk);
        check("midrst_d0_x", int'(xo[0]), 0);
        check("midrst_d0_y", int'(yo[0]), 0);
        check("midrst_d0_hsync", int'(hs[0]), 1);
        check("midrst_d0_vsync", int'(vs[0]), 1);
        check("midrst_d0_rgb", int'({ro[0], go[0], bo[0]}), 0);
        check("midrst_d0_pix_en", int'(pix_en[0]), 0);
        rst[0]  = 1'b0;
        mode[1] = 1;
        @(negedge clk);
        check("midrst_d0_first_pix_en", int'(pix_en[0]), 1);
        check("midrst_d0_x_hold", int'(xo[0]), 0);
        check("midrst_d1_frozen_x", int'(xo[1]), 0);
        rst[1] = 1'b0;

        repeat (3000) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
